// File: rtl/ahb_matrix_pkg.sv
// Shared AHB encodings and the address/control bundle used by the DMA bus matrix input stage.
// The bundle is also where replay rewriting (SEQ->NONSEQ, fixed bursts->INCR) lives.
package ahb_matrix_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [3:0]  master;
    logic        mastlock;
  } addr_ctrl_t;

  typedef enum logic [1:0] {
    TO_IDLE       = 2'b00,
    TO_ERR_FIRST  = 2'b01,
    TO_ERR_SECOND = 2'b10
  } to_state_e;

  // A replayed beat starts a fresh access at the slave, so it cannot claim burst continuity.
  function automatic addr_ctrl_t replay_ctrl(input addr_ctrl_t c);
    addr_ctrl_t r;
    r = c;
    if (c.trans == HTRANS_SEQ) r.trans = HTRANS_NONSEQ;
    if ((c.burst != HBURST_SINGLE) && (c.burst != HBURST_INCR)) r.burst = HBURST_INCR;
    return r;
  endfunction

endpackage

// File: rtl/ahb_instage_timeout.sv
// Pending-transfer watchdog: counts cycles a held transfer waits and, on expiry,
// sequences the two-cycle AHB ERROR response. Only instantiated with AHB_INSTAGE_TIMEOUT_EN.
module ahb_instage_timeout
  import ahb_matrix_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic      HCLK,
  input  logic      HRESETn,
  input  logic      pend_tran,
  input  logic      grant,
  output logic      expire,
  output to_state_e state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;
  to_state_e        state_nxt;

  // Grant in the expiry cycle wins, so no error is raised then.
  assign expire = pend_tran & ~grant & (cnt == LAST);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt <= '0;
    end else if (!pend_tran || grant || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= TO_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      TO_IDLE:       if (expire) state_nxt = TO_ERR_FIRST;
      TO_ERR_FIRST:  state_nxt = TO_ERR_SECOND;
      TO_ERR_SECOND: state_nxt = TO_IDLE;
      default:       state_nxt = TO_IDLE;
    endcase
  end

endmodule

// File: rtl/ahb_input_stage_dmam.sv
// Per-master input stage of the DMA bus matrix: passes address phases through or holds them
// until the output stage grants, and returns ready/response. Optional timeout: AHB_INSTAGE_TIMEOUT_EN.
module ahb_input_stage_dmam
  import ahb_matrix_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic [3:0]  HMASTERS,
  input  logic        HMASTLOCKS,
  input  logic        HREADYS,
  input  logic        active_ip,
  input  logic        readymux_ip,
  input  logic        readyout_ip,
  input  logic        resp_ip,
  output logic        sel_ip,
  output logic [31:0] addr_ip,
  output logic [1:0]  trans_ip,
  output logic        write_ip,
  output logic [2:0]  size_ip,
  output logic [2:0]  burst_ip,
  output logic [3:0]  prot_ip,
  output logic [3:0]  master_ip,
  output logic        mastlock_ip,
  output logic        held_tran_ip,
  output logic        HREADYOUTS,
  output logic        HRESPS
);

  addr_ctrl_t live_ctrl, hold_ctrl, out_ctrl;
  logic       pend_tran, data_phase, live_tran, grant;
  logic       expire, err_active, err_ready;

  assign live_ctrl = '{sel: HSELS, addr: HADDRS, trans: HTRANSS, write: HWRITES, size: HSIZES,
                       burst: HBURSTS, prot: HPROTS, master: HMASTERS, mastlock: HMASTLOCKS};

  assign live_tran    = HSELS & HTRANSS[1] & HREADYS;
  assign held_tran_ip = pend_tran | live_tran;
  assign grant        = active_ip & readymux_ip & held_tran_ip;

`ifdef AHB_INSTAGE_TIMEOUT_EN
  to_state_e to_state;

  ahb_instage_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .pend_tran (pend_tran),
    .grant     (grant),
    .expire    (expire),
    .state     (to_state)
  );

  assign err_active = (to_state != TO_IDLE);
  assign err_ready  = (to_state == TO_ERR_SECOND);
`else
  assign expire     = 1'b0;
  assign err_active = 1'b0;
  assign err_ready  = 1'b1;
`endif

  // Capturing on every HREADYS cycle means the regs already hold the beat when it must be kept.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)     hold_ctrl <= '0;
    else if (HREADYS) hold_ctrl <= live_ctrl;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)              pend_tran <= 1'b0;
    else if (grant || expire)  pend_tran <= 1'b0;
    else if (live_tran)        pend_tran <= 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)         data_phase <= 1'b0;
    else if (grant)       data_phase <= 1'b1;
    else if (readyout_ip) data_phase <= 1'b0;
  end

  assign out_ctrl    = pend_tran ? replay_ctrl(hold_ctrl) : live_ctrl;
  assign sel_ip      = out_ctrl.sel;
  assign addr_ip     = out_ctrl.addr;
  assign trans_ip    = out_ctrl.trans;
  assign write_ip    = out_ctrl.write;
  assign size_ip     = out_ctrl.size;
  assign burst_ip    = out_ctrl.burst;
  assign prot_ip     = out_ctrl.prot;
  assign master_ip   = out_ctrl.master;
  assign mastlock_ip = out_ctrl.mastlock;

  // Slave ERROR responses are forwarded cycle-for-cycle; only a timeout generates its own.
  always_comb begin
    HREADYOUTS = ~pend_tran;
    HRESPS     = HRESP_OKAY;
    if (err_active) begin
      HREADYOUTS = err_ready;
      HRESPS     = HRESP_ERROR;
    end else if (data_phase) begin
      HREADYOUTS = readyout_ip;
      HRESPS     = resp_ip;
    end
  end

endmodule

// File: tb/tb_ahb_input_stage_dmam.sv
// Directed bench for ahb_input_stage_dmam: per-cycle model comparison, address scoreboard,
// and literal spot checks. Exercises the timeout path when AHB_INSTAGE_TIMEOUT_EN is defined.
module tb_ahb_input_stage_dmam;

  localparam int TO = 4;

  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
    logic [2:0]  burst;
    logic [3:0]  prot;
    logic [3:0]  master;
    logic        mastlock;
  } xfer_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSELS, HWRITES, HMASTLOCKS, HREADYS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic [2:0]  HSIZES, HBURSTS;
  logic [3:0]  HPROTS, HMASTERS;
  logic        active_ip, readymux_ip, readyout_ip, resp_ip;
  logic        sel_ip, write_ip, mastlock_ip, held_tran_ip, HREADYOUTS, HRESPS;
  logic [31:0] addr_ip;
  logic [1:0]  trans_ip;
  logic [2:0]  size_ip, burst_ip;
  logic [3:0]  prot_ip, master_ip;

  int tests_run = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  // model state
  logic  m_pend = 1'b0;
  logic  m_dp = 1'b0;
  int    m_err = 0;
  int    m_wait = 0;
  xfer_t m_hold = '0;

  // clock / reset
  always #5 HCLK = ~HCLK;

  // The master sees the stage's own ready as its HREADY.
  assign HREADYS = HREADYOUTS;

  ahb_input_stage_dmam #(.TIMEOUT_CYCLES(TO)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HMASTERS(HMASTERS), .HMASTLOCKS(HMASTLOCKS), .HREADYS(HREADYS),
    .active_ip(active_ip), .readymux_ip(readymux_ip), .readyout_ip(readyout_ip),
    .resp_ip(resp_ip), .sel_ip(sel_ip), .addr_ip(addr_ip), .trans_ip(trans_ip),
    .write_ip(write_ip), .size_ip(size_ip), .burst_ip(burst_ip), .prot_ip(prot_ip),
    .master_ip(master_ip), .mastlock_ip(mastlock_ip), .held_tran_ip(held_tran_ip),
    .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic xfer_t replayed(input xfer_t x);
    xfer_t r;
    r = x;
    if (x.trans == 2'd3) r.trans = 2'd2;
    if (x.burst >= 3'd2) r.burst = 3'd1;
    return r;
  endfunction

  // driver tasks
  task automatic drive(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                       input logic [2:0] burst, input logic act, input logic rmux,
                       input logic rout, input logic resp);
    HSELS = sel; HADDRS = addr; HTRANSS = trans; HBURSTS = burst;
    HWRITES = addr[3]; HSIZES = 3'b010; HPROTS = 4'($urandom_range(0, 15));
    HMASTERS = 4'd3; HMASTLOCKS = 1'b0;
    active_ip = act; readymux_ip = rmux; readyout_ip = rout; resp_ip = resp;
    #1;
    if (sel && trans[1] && HREADYS) exp_q.push_back(addr);
  endtask

  task automatic idle(input logic rout, input logic resp);
    drive(1'b0, 32'h0, 2'b00, 3'b000, 1'b0, 1'b1, rout, resp);
  endtask

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  // compare process: model outputs vs DUT every cycle
  always @(negedge HCLK) begin
    xfer_t cur, e;
    logic  live, held, grant, e_rdy, e_resp;
    logic [31:0] front;
    if (!HRESETn) begin
      m_pend = 1'b0; m_dp = 1'b0; m_err = 0; m_wait = 0;
      exp_q.delete();
    end
    cur = '{HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTERS, HMASTLOCKS};
    live  = HSELS & HTRANSS[1] & HREADYS;
    held  = m_pend | live;
    grant = active_ip & readymux_ip & held;
    e     = m_pend ? replayed(m_hold) : cur;
    if (m_err == 1)      begin e_rdy = 1'b0; e_resp = 1'b1; end
    else if (m_err == 2) begin e_rdy = 1'b1; e_resp = 1'b1; end
    else if (m_dp)       begin e_rdy = readyout_ip; e_resp = resp_ip; end
    else                 begin e_rdy = !m_pend; e_resp = 1'b0; end

    check("sel_ip", 32'(sel_ip), 32'(e.sel));
    check("addr_ip", addr_ip, e.addr);
    check("trans_ip", 32'(trans_ip), 32'(e.trans));
    check("write_ip", 32'(write_ip), 32'(e.write));
    check("size_ip", 32'(size_ip), 32'(e.size));
    check("burst_ip", 32'(burst_ip), 32'(e.burst));
    check("prot_ip", 32'(prot_ip), 32'(e.prot));
    check("master_ip", 32'(master_ip), 32'(e.master));
    check("mastlock_ip", 32'(mastlock_ip), 32'(e.mastlock));
    check("held_tran_ip", 32'(held_tran_ip), 32'(held));
    check("HREADYOUTS", 32'(HREADYOUTS), 32'(e_rdy));
    check("HRESPS", 32'(HRESPS), 32'(e_resp));

    if (HRESETn) begin
      if (grant) begin
        if (exp_q.size() == 0) begin
          check("grant_without_transfer", 32'(exp_q.size()), 32'd1);
        end else begin
          front = exp_q.pop_front();
          check("granted_addr", addr_ip, front);
        end
      end
      m_err = (m_err == 1) ? 2 : 0;
      if (grant) begin
        m_pend = 1'b0; m_dp = 1'b1; m_wait = 0;
      end else begin
        if (m_dp && readyout_ip) m_dp = 1'b0;
        if (m_pend) begin
          m_wait++;
`ifdef AHB_INSTAGE_TIMEOUT_EN
          if (m_wait == TO) begin
            m_pend = 1'b0; m_wait = 0; m_err = 1;
            if (exp_q.size() != 0) exp_q.pop_front();
          end
`endif
        end else if (live) begin
          m_pend = 1'b1; m_hold = cur; m_wait = 0;
        end
      end
    end
  end

  initial begin
    HRESETn = 1'b0;
    HSELS = 0; HADDRS = 0; HTRANSS = 0; HWRITES = 0; HSIZES = 0; HBURSTS = 0;
    HPROTS = 0; HMASTERS = 0; HMASTLOCKS = 0;
    active_ip = 0; readymux_ip = 0; readyout_ip = 1; resp_ip = 0;
    repeat (2) @(posedge HCLK);
    #2;
    check("reset_hreadyouts", 32'(HREADYOUTS), 32'd1);
    check("reset_hresps", 32'(HRESPS), 32'd0);
    check("reset_held", 32'(held_tran_ip), 32'd0);
    next_cycle();
    HRESETn = 1'b1;

    // 1: granted immediately, zero-latency pass-through
    drive(1, 32'h1000, 2'b10, 3'b000, 1, 1, 1, 0);
    check("t1_addr", addr_ip, 32'h1000);
    check("t1_held", 32'(held_tran_ip), 32'd1);
    check("t1_ready", 32'(HREADYOUTS), 32'd1);
    next_cycle();
    idle(0, 0);
    check("t1_dp_wait", 32'(HREADYOUTS), 32'd0);
    next_cycle();
    idle(1, 0);
    check("t1_dp_done", 32'(HREADYOUTS), 32'd1);
    next_cycle();

    // 2: held for three cycles, then granted
    drive(1, 32'h2000, 2'b10, 3'b000, 0, 1, 1, 0);
    next_cycle();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h2000, 2'b10, 3'b000, 0, 1, 1, 0);
      check("t2_held", 32'(held_tran_ip), 32'd1);
      check("t2_addr", addr_ip, 32'h2000);
      check("t2_ready", 32'(HREADYOUTS), 32'd0);
      next_cycle();
    end
    drive(1, 32'h2000, 2'b10, 3'b000, 1, 1, 1, 0);
    check("t2_grant_ready", 32'(HREADYOUTS), 32'd0);
    next_cycle();
    idle(0, 0);
    check("t2_slave_wait", 32'(HREADYOUTS), 32'd0);
    next_cycle();
    idle(1, 0);
    next_cycle();

    // 3: held SEQ beat of INCR4 replays as NONSEQ/INCR from the holding regs
    drive(1, 32'h2008, 2'b11, 3'b011, 0, 1, 1, 0);
    check("t3_live_trans", 32'(trans_ip), 32'd3);
    next_cycle();
    drive(1, 32'h3000, 2'b10, 3'b000, 1, 0, 1, 0);
    check("t3_trans", 32'(trans_ip), 32'd2);
    check("t3_burst", 32'(burst_ip), 32'd1);
    check("t3_addr", addr_ip, 32'h2008);
    next_cycle();
    drive(1, 32'h2008, 2'b11, 3'b011, 1, 1, 1, 0);
    next_cycle();
    idle(1, 0);
    next_cycle();

    // 4: two-cycle slave ERROR passes straight through
    drive(1, 32'h4000, 2'b10, 3'b000, 1, 1, 1, 0);
    next_cycle();
    idle(0, 1);
    check("t4_err1_resp", 32'(HRESPS), 32'd1);
    check("t4_err1_ready", 32'(HREADYOUTS), 32'd0);
    next_cycle();
    idle(1, 1);
    check("t4_err2_resp", 32'(HRESPS), 32'd1);
    check("t4_err2_ready", 32'(HREADYOUTS), 32'd1);
    next_cycle();
    idle(1, 0);
    check("t4_after_resp", 32'(HRESPS), 32'd0);
    next_cycle();

`ifdef AHB_INSTAGE_TIMEOUT_EN
    // 5a: never granted -> drop after TO cycles, then ERROR pair
    drive(1, 32'h5000, 2'b10, 3'b000, 0, 1, 1, 0);
    next_cycle();
    for (int i = 0; i < TO; i++) begin
      drive(1, 32'h5000, 2'b10, 3'b000, 0, 1, 1, 0);
      check("t5_pending", 32'(held_tran_ip), 32'd1);
      next_cycle();
    end
    idle(1, 0);
    check("t5_dropped", 32'(held_tran_ip), 32'd0);
    check("t5_err1_ready", 32'(HREADYOUTS), 32'd0);
    check("t5_err1_resp", 32'(HRESPS), 32'd1);
    next_cycle();
    idle(1, 0);
    check("t5_err2_ready", 32'(HREADYOUTS), 32'd1);
    check("t5_err2_resp", 32'(HRESPS), 32'd1);
    next_cycle();
    idle(1, 0);
    check("t5_err_done", 32'(HRESPS), 32'd0);
    next_cycle();
    // 5b: grant in the expiry cycle wins
    drive(1, 32'h5100, 2'b10, 3'b000, 0, 1, 1, 0);
    next_cycle();
    for (int i = 0; i < TO; i++) begin
      drive(1, 32'h5100, 2'b10, 3'b000, (i == TO - 1), 1, 1, 0);
      next_cycle();
    end
    idle(1, 0);
    check("t5_grant_wins_resp", 32'(HRESPS), 32'd0);
    check("t5_grant_wins_ready", 32'(HREADYOUTS), 32'd1);
    next_cycle();
`else
    // 5: without the watchdog a pending transfer waits indefinitely
    drive(1, 32'h5000, 2'b10, 3'b000, 0, 1, 1, 0);
    next_cycle();
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h5000, 2'b10, 3'b000, 0, 1, 1, 0);
      next_cycle();
    end
    drive(1, 32'h5000, 2'b10, 3'b000, 0, 1, 1, 0);
    check("t5_still_pending", 32'(held_tran_ip), 32'd1);
    check("t5_no_error", 32'(HRESPS), 32'd0);
    next_cycle();
    drive(1, 32'h5000, 2'b10, 3'b000, 1, 1, 1, 0);
    next_cycle();
    idle(1, 0);
    next_cycle();
`endif

    // 6: async reset while pending, then BUSY/IDLE never held
    drive(1, 32'h6000, 2'b10, 3'b000, 0, 1, 1, 0);
    next_cycle();
    drive(1, 32'h6000, 2'b10, 3'b000, 0, 1, 1, 0);
    check("t6_pending", 32'(held_tran_ip), 32'd1);
    #1;
    HRESETn = 1'b0;
    HSELS = 1'b0;
    #1;
    check("t6_rst_held", 32'(held_tran_ip), 32'd0);
    check("t6_rst_ready", 32'(HREADYOUTS), 32'd1);
    check("t6_rst_resp", 32'(HRESPS), 32'd0);
    next_cycle();
    HRESETn = 1'b1;
    idle(1, 0);
    next_cycle();
    drive(1, 32'h7000, 2'b01, 3'b001, 0, 1, 1, 0);
    check("t6_busy_held", 32'(held_tran_ip), 32'd0);
    next_cycle();
    drive(1, 32'h7004, 2'b00, 3'b000, 0, 1, 1, 0);
    check("t6_busy_ready", 32'(HREADYOUTS), 32'd1);
    check("t6_idle_held", 32'(held_tran_ip), 32'd0);
    next_cycle();
    idle(1, 0);
    next_cycle();
    idle(1, 0);
    next_cycle();

    // final report
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
